// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending controller: FSM state encoding,
// default slot price and price-table lookup.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_PRICE = 10;
  localparam int unsigned MAX_PRODUCTS  = 16;
  localparam int unsigned MAX_CREDIT_W  = 32;
  localparam int unsigned TABLE_W       = MAX_PRODUCTS * MAX_CREDIT_W;

  // Slot idx occupies bits [idx*credit_w +: credit_w]; out-of-table slots read 0.
  function automatic logic [MAX_CREDIT_W-1:0] price_of(
    input logic [TABLE_W-1:0] tbl,
    input int unsigned        idx,
    input int unsigned        credit_w
  );
    logic [TABLE_W-1:0]      shifted;
    logic [MAX_CREDIT_W-1:0] mask;
    shifted = tbl >> (idx * credit_w);
    mask = (credit_w >= MAX_CREDIT_W) ? '1
         : ((MAX_CREDIT_W'(1) << credit_w) - MAX_CREDIT_W'(1));
    return shifted[MAX_CREDIT_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-slot stock counters: refill to full on restock, decrement one slot per
// vend (saturating at zero), and expose a sold-out flag per slot.
module vend_stock_bank
  import vending_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int STOCK_W      = 4,
  parameter int ID_W         = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dec_en,
  input  logic [ID_W-1:0]         dec_id,
  input  logic                    restock_en,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  localparam logic [STOCK_W-1:0] FULL_STOCK = '1;

  logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= FULL_STOCK;
    end else if (restock_en) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= FULL_STOCK;
    end else if (dec_en) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        if (ID_W'(i) == dec_id && stock_q[i] != '0)
          stock_q[i] <= stock_q[i] - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) sold_out[i] = (stock_q[i] == '0);
  end

endmodule

// File: rtl/vending_controller.sv
// Coin-operated vending controller: accumulates credit, vends a selected slot,
// returns change, refunds on cancel or idle timeout. Pulse outputs are registered.
module vending_controller
  import vending_pkg::*;
#(
  parameter int NUM_PRODUCTS   = 4,
  parameter int CREDIT_W       = 8,
  parameter int STOCK_W        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_TABLE =
    {NUM_PRODUCTS{CREDIT_W'(DEFAULT_PRICE)}}
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            coin_valid,
  input  logic [CREDIT_W-1:0]             coin_value,
  input  logic                            sel_valid,
  input  logic [$clog2(NUM_PRODUCTS)-1:0] sel_id,
  input  logic                            cancel,
  input  logic                            restock,
  output logic                            dispense,
  output logic [$clog2(NUM_PRODUCTS)-1:0] dispense_id,
  output logic                            change_valid,
  output logic [CREDIT_W-1:0]             change_amount,
  output logic                            coin_reject,
  output logic                            sel_reject,
  output logic [CREDIT_W-1:0]             credit,
  output logic [NUM_PRODUCTS-1:0]         sold_out,
  output logic                            busy,
  output state_t                          state_dbg
);

  localparam int ID_W    = $clog2(NUM_PRODUCTS);
  localparam int ID_SPAN = 1 << ID_W;
  localparam int TMR_W   = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [ID_W-1:0]     dispense_id_d;
  logic [CREDIT_W-1:0] change_amount_d;
  logic                dispense_d, change_valid_d, coin_reject_d, sel_reject_d;
  logic                restock_en;

  logic [CREDIT_W-1:0] sel_price;
  logic [ID_SPAN-1:0]  sold_ext;
  logic                id_bad;
  logic [CREDIT_W:0]   coin_sum;

  assign sel_price = CREDIT_W'(price_of(TABLE_W'(PRICE_TABLE), int'(sel_id), CREDIT_W));
  assign sold_ext  = ID_SPAN'(sold_out);
  // Widened compare so the range check stays meaningful for non-power-of-two slot counts.
  assign id_bad    = ({1'b0, sel_id} >= (ID_W+1)'(NUM_PRODUCTS)) || sold_ext[sel_id];
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    timer_d         = timer_q;
    dispense_d      = 1'b0;
    dispense_id_d   = '0;
    change_valid_d  = 1'b0;
    change_amount_d = '0;
    coin_reject_d   = 1'b0;
    sel_reject_d    = 1'b0;
    restock_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d    = '0;
        restock_en = restock;
        if (coin_valid) begin
          credit_d = coin_value;
          state_d  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (cancel) begin
          state_d         = ST_CHANGE;
          change_valid_d  = 1'b1;
          change_amount_d = credit_q;
          coin_reject_d   = coin_valid;
        end else if (sel_valid && !id_bad && credit_q >= sel_price) begin
          credit_d      = credit_q - sel_price;
          state_d       = ST_DISPENSE;
          dispense_d    = 1'b1;
          dispense_id_d = sel_id;
          coin_reject_d = coin_valid;
        end else begin
          // Refused or unaffordable selections fall through to coin/timeout handling.
          sel_reject_d = sel_valid && id_bad;
          if (coin_valid && !coin_sum[CREDIT_W]) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            timer_d  = '0;
          end else begin
            coin_reject_d = coin_valid;
            if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
              state_d         = ST_CHANGE;
              change_valid_d  = 1'b1;
              change_amount_d = credit_q;
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
      end
      ST_DISPENSE: begin
        coin_reject_d = coin_valid;
        if (credit_q != '0) begin
          state_d         = ST_CHANGE;
          change_valid_d  = 1'b1;
          change_amount_d = credit_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        credit_d      = '0;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      timer_q       <= '0;
      dispense      <= 1'b0;
      dispense_id   <= '0;
      change_valid  <= 1'b0;
      change_amount <= '0;
      coin_reject   <= 1'b0;
      sel_reject    <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      timer_q       <= timer_d;
      dispense      <= dispense_d;
      dispense_id   <= dispense_id_d;
      change_valid  <= change_valid_d;
      change_amount <= change_amount_d;
      coin_reject   <= coin_reject_d;
      sel_reject    <= sel_reject_d;
    end
  end

  // dispense_id holds the latched slot for the whole DISPENSE cycle.
  vend_stock_bank #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .STOCK_W      (STOCK_W),
    .ID_W         (ID_W)
  ) u_stock (
    .clk        (clk),
    .rst_n      (reset_n),
    .dec_en     (state_q == ST_DISPENSE),
    .dec_id     (dispense_id),
    .restock_en (restock_en),
    .sold_out   (sold_out)
  );

  assign credit    = credit_q;
  assign busy      = (state_q == ST_DISPENSE) || (state_q == ST_CHANGE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller with default parameters (4 slots,
// price 10, 8-bit credit, 4-bit stock, 64-cycle timeout).
module tb_vending_controller;
  import vending_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       coin_valid;
  logic [7:0] coin_value;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       restock;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       coin_reject;
  logic       sel_reject;
  logic [7:0] credit;
  logic [3:0] sold_out;
  logic       busy;
  state_t     state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  vending_controller dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .coin_valid    (coin_valid),
    .coin_value    (coin_value),
    .sel_valid     (sel_valid),
    .sel_id        (sel_id),
    .cancel        (cancel),
    .restock       (restock),
    .dispense      (dispense),
    .dispense_id   (dispense_id),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .coin_reject   (coin_reject),
    .sel_reject    (sel_reject),
    .credit        (credit),
    .sold_out      (sold_out),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert_coin(input logic [7:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
    coin_value = '0;
  endtask

  task automatic do_select(input logic [1:0] id);
    sel_valid = 1'b1;
    sel_id    = id;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  // scoreboard: every change pulse must match the next expected refund
  always @(negedge clk) begin
    if (change_valid) begin
      if (exp_q.size() == 0) check_eq("change_unexpected", 32'd1, 32'd0);
      else check_eq("change_amount_sb", 32'(change_amount), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    coin_valid = 1'b0;
    coin_value = '0;
    sel_valid  = 1'b0;
    sel_id     = '0;
    cancel     = 1'b0;
    restock    = 1'b0;
    tick();
    tick();
    check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("rst_credit", 32'(credit), 32'd0);
    check_eq("rst_sold_out", 32'(sold_out), 32'd0);
    check_eq("rst_pulses", 32'({dispense, change_valid, coin_reject, sel_reject, busy}), 32'd0);
    reset_n = 1'b1;
    tick();

    // 5 + 5, buy slot 1 at exact price
    insert_coin(8'd5);
    check_eq("t1_state_credit", 32'(state_dbg), 32'(ST_CREDIT));
    check_eq("t1_credit5", 32'(credit), 32'd5);
    insert_coin(8'd5);
    check_eq("t1_credit10", 32'(credit), 32'd10);
    do_select(2'd1);
    check_eq("t1_dispense", 32'(dispense), 32'd1);
    check_eq("t1_dispense_id", 32'(dispense_id), 32'd1);
    check_eq("t1_credit0", 32'(credit), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd1);
    tick();
    check_eq("t1_dispense_off", 32'(dispense), 32'd0);
    check_eq("t1_no_change", 32'(change_valid), 32'd0);
    check_eq("t1_idle", 32'(state_dbg), 32'(ST_IDLE));

    // coin 20, buy slot 0, change 10
    insert_coin(8'd20);
    exp_q.push_back(8'd10);
    do_select(2'd0);
    check_eq("t2_dispense", 32'(dispense), 32'd1);
    check_eq("t2_dispense_id", 32'(dispense_id), 32'd0);
    tick();
    check_eq("t2_change_valid", 32'(change_valid), 32'd1);
    check_eq("t2_change_amount", 32'(change_amount), 32'd10);
    check_eq("t2_state_change", 32'(state_dbg), 32'(ST_CHANGE));
    tick();
    check_eq("t2_change_off", 32'(change_valid), 32'd0);
    check_eq("t2_idle", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("t2_credit0", 32'(credit), 32'd0);

    // credit overflow
    insert_coin(8'd250);
    insert_coin(8'd10);
    check_eq("t3_coin_reject", 32'(coin_reject), 32'd1);
    check_eq("t3_credit_hold", 32'(credit), 32'd250);
    tick();
    check_eq("t3_reject_pulse", 32'(coin_reject), 32'd0);
    exp_q.push_back(8'd250);
    do_cancel();
    check_eq("t3_cancel_change", 32'(change_valid), 32'd1);
    tick();

    // unaffordable selection is silent; coin with cancel is returned
    insert_coin(8'd5);
    do_select(2'd3);
    check_eq("t4_no_dispense", 32'(dispense), 32'd0);
    check_eq("t4_no_sel_reject", 32'(sel_reject), 32'd0);
    check_eq("t4_credit_kept", 32'(credit), 32'd5);
    check_eq("t4_state_credit", 32'(state_dbg), 32'(ST_CREDIT));
    exp_q.push_back(8'd5);
    coin_valid = 1'b1;
    coin_value = 8'd3;
    do_cancel();
    coin_valid = 1'b0;
    check_eq("t4_coin_reject", 32'(coin_reject), 32'd1);
    check_eq("t4_change_amount", 32'(change_amount), 32'd5);
    tick();

    // cancel with credit 3
    insert_coin(8'd3);
    exp_q.push_back(8'd3);
    do_cancel();
    check_eq("t5_change_amount", 32'(change_amount), 32'd3);
    tick();

    // idle timeout refund after 64 cycles in CREDIT
    insert_coin(8'd7);
    for (int i = 0; i < 63; i++) tick();
    check_eq("t6_still_credit", 32'(state_dbg), 32'(ST_CREDIT));
    exp_q.push_back(8'd7);
    tick();
    check_eq("t6_timeout_change", 32'(change_valid), 32'd1);
    check_eq("t6_timeout_amount", 32'(change_amount), 32'd7);
    tick();
    check_eq("t6_idle", 32'(state_dbg), 32'(ST_IDLE));

    // coin during DISPENSE is returned
    insert_coin(8'd10);
    do_select(2'd0);
    coin_valid = 1'b1;
    coin_value = 8'd5;
    tick();
    coin_valid = 1'b0;
    check_eq("t7_coin_reject", 32'(coin_reject), 32'd1);
    check_eq("t7_credit0", 32'(credit), 32'd0);
    check_eq("t7_idle", 32'(state_dbg), 32'(ST_IDLE));

    // empty slot 2 (15 units)
    for (int i = 0; i < 15; i++) begin
      insert_coin(8'd10);
      do_select(2'd2);
      tick();
    end
    check_eq("t8_sold_out", 32'(sold_out), 32'b0100);
    insert_coin(8'd50);
    do_select(2'd2);
    check_eq("t8_sel_reject", 32'(sel_reject), 32'd1);
    check_eq("t8_no_dispense", 32'(dispense), 32'd0);
    check_eq("t8_credit_kept", 32'(credit), 32'd50);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    check_eq("t8_restock_ignored", 32'(sold_out), 32'b0100);
    exp_q.push_back(8'd50);
    do_cancel();
    tick();
    restock = 1'b1;
    tick();
    restock = 1'b0;
    check_eq("t8_restocked", 32'(sold_out), 32'd0);

    // reset in DISPENSE
    insert_coin(8'd20);
    do_select(2'd1);
    check_eq("t9_in_dispense", 32'(state_dbg), 32'(ST_DISPENSE));
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t9_rst_pulses", 32'({dispense, change_valid, busy}), 32'd0);
    check_eq("t9_rst_id", 32'(dispense_id), 32'd0);
    check_eq("t9_rst_credit", 32'(credit), 32'd0);
    check_eq("t9_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_eq("t9_post_idle", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("t9_post_no_change", 32'(change_valid), 32'd0);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
